// File: rtl/bullet_pool_if.sv
// Bullet pool bus: the fire request, the per-slot hit flags and the ship
// column go in; the per-slot positions, the active mask and the
// fired/full flags come out. The master side drives requests, and the
// slave side is the pool itself.
interface bullet_pool_if #(
    parameter int N_BULLETS = 4,
    parameter int X_WIDTH   = 5,
    parameter int Y_WIDTH   = 4
);
    logic                           i_shoot;
    logic [N_BULLETS-1:0]           i_hit;
    logic [X_WIDTH-1:0]             i_ship_x;
    logic [N_BULLETS*X_WIDTH-1:0]   o_bullet_x;
    logic [N_BULLETS*Y_WIDTH-1:0]   o_bullet_y;
    logic [N_BULLETS-1:0]           o_active;
    logic                           o_fired;
    logic                           o_full;

    modport master (
        output i_shoot, i_hit, i_ship_x,
        input  o_bullet_x, o_bullet_y, o_active, o_fired, o_full
    );

    modport slave (
        input  i_shoot, i_hit, i_ship_x,
        output o_bullet_x, o_bullet_y, o_active, o_fired, o_full
    );
endinterface

// File: rtl/bullet_pool.sv
// Player projectile pool. It holds up to N_BULLETS independent bullets.
// Each bullet spawns at the ship column on SPAWN_Y and climbs one row per
// move tick. A bullet retires when it is hit or when it steps off row 0.
// A cooldown, counted in move ticks, spaces consecutive shots.
module bullet_pool #(
    parameter int N_BULLETS      = 4,
    parameter int X_WIDTH        = 5,
    parameter int Y_WIDTH        = 4,
    parameter int SPAWN_Y        = 12,
    parameter int TICK_CYCLES    = 90000,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic          i_clk_25MHz,
    input  logic          i_reset,
    bullet_pool_if.slave  bus
);
    typedef enum logic {IDLE, MOVING} slot_state_t;

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam int CD_W   = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);
    localparam logic [Y_WIDTH-1:0] Y_OFF = '1;

    slot_state_t        state_q [N_BULLETS];
    slot_state_t        state_d [N_BULLETS];
    logic [X_WIDTH-1:0] x_q     [N_BULLETS];
    logic [X_WIDTH-1:0] x_d     [N_BULLETS];
    logic [Y_WIDTH-1:0] y_q     [N_BULLETS];
    logic [Y_WIDTH-1:0] y_d     [N_BULLETS];

    logic [TICK_W-1:0]    tick_cnt_q;
    logic                 tick;
    logic [CD_W-1:0]      cooldown_q;
    logic [CD_W-1:0]      cooldown_d;
    logic                 fired_q;
    logic                 spawn;
    logic                 free_found;
    logic [N_BULLETS-1:0] spawn_sel;
    logic [N_BULLETS-1:0] active;

    assign tick = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));

    // Free-running move-tick divider. It wraps after the tick cycle.
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Pick the lowest-index idle slot. The choice uses the state before
    // the edge, so a slot retiring this cycle cannot be reused until the
    // next cycle.
    always_comb begin
        spawn_sel  = '0;
        free_found = 1'b0;
        for (int k = 0; k < N_BULLETS; k++) begin
            if (state_q[k] == IDLE && !free_found) begin
                spawn_sel[k] = 1'b1;
                free_found   = 1'b1;
            end
        end
    end

    assign spawn = bus.i_shoot && (cooldown_q == '0) && free_found;

    // Per-slot next state. A hit wins over movement. A tick on row 0
    // retires the bullet instead of wrapping it to the off-screen row.
    always_comb begin
        for (int k = 0; k < N_BULLETS; k++) begin
            state_d[k] = state_q[k];
            x_d[k]     = x_q[k];
            y_d[k]     = y_q[k];
            case (state_q[k])
                IDLE: begin
                    if (spawn && spawn_sel[k]) begin
                        state_d[k] = MOVING;
                        x_d[k]     = bus.i_ship_x;
                        y_d[k]     = Y_WIDTH'(SPAWN_Y);
                    end
                end
                MOVING: begin
                    if (bus.i_hit[k] || (tick && y_q[k] == '0)) begin
                        state_d[k] = IDLE;
                        x_d[k]     = '0;
                        y_d[k]     = Y_OFF;
                    end else if (tick) begin
                        y_d[k] = y_q[k] - 1'b1;
                    end
                end
                default: begin
                    state_d[k] = IDLE;
                    x_d[k]     = '0;
                    y_d[k]     = Y_OFF;
                end
            endcase
        end
    end

    // The cooldown reloads on every shot and counts down one step per
    // move tick. It stops at zero.
    always_comb begin
        cooldown_d = cooldown_q;
        if (spawn) begin
            cooldown_d = CD_W'(COOLDOWN_TICKS);
        end else if (tick && cooldown_q != '0) begin
            cooldown_d = cooldown_q - 1'b1;
        end
    end

    // Slot, cooldown and fired-pulse registers.
    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            for (int k = 0; k < N_BULLETS; k++) begin
                state_q[k] <= IDLE;
                x_q[k]     <= '0;
                y_q[k]     <= Y_OFF;
            end
            cooldown_q <= '0;
            fired_q    <= 1'b0;
        end else begin
            for (int k = 0; k < N_BULLETS; k++) begin
                state_q[k] <= state_d[k];
                x_q[k]     <= x_d[k];
                y_q[k]     <= y_d[k];
            end
            cooldown_q <= cooldown_d;
            fired_q    <= spawn;
        end
    end

    // Pack the slot registers onto the flat output buses.
    always_comb begin
        bus.o_bullet_x = '0;
        bus.o_bullet_y = '0;
        active         = '0;
        for (int k = 0; k < N_BULLETS; k++) begin
            bus.o_bullet_x[k*X_WIDTH +: X_WIDTH] = x_q[k];
            bus.o_bullet_y[k*Y_WIDTH +: Y_WIDTH] = y_q[k];
            active[k]                            = (state_q[k] == MOVING);
        end
    end

    assign bus.o_active = active;
    assign bus.o_fired  = fired_q;
    assign bus.o_full   = &active;
endmodule

// File: tb/tb_bullet_pool.sv
// Testbench for bullet_pool. A high-level model tracks every slot as a
// live flag plus a column and a row, and tracks the cooldown and the tick
// phase as plain integers. The bench compares the DUT against this model
// every cycle, and adds direct checks on the values the scenarios call out.
module tb_bullet_pool;
    localparam int N       = 4;
    localparam int XW      = 5;
    localparam int YW      = 4;
    localparam int SPAWN_Y = 12;
    localparam int TICKS   = 4;
    localparam int CD      = 1;
    localparam int SNAP_W  = N + 2 + N*XW + N*YW;

    logic i_clk_25MHz;
    logic i_reset;

    bullet_pool_if #(.N_BULLETS(N), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    bullet_pool #(
        .N_BULLETS(N), .X_WIDTH(XW), .Y_WIDTH(YW), .SPAWN_Y(SPAWN_Y),
        .TICK_CYCLES(TICKS), .COOLDOWN_TICKS(CD)
    ) dut (
        .i_clk_25MHz(i_clk_25MHz),
        .i_reset(i_reset),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;

    bit m_active [N];
    int m_x      [N];
    int m_y      [N];
    int m_cd;
    int m_phase;
    bit m_fired;

    initial begin
        i_clk_25MHz = 1'b0;
        forever #20 i_clk_25MHz = ~i_clk_25MHz;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N-1:0] exp_active();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_active[k];
        return v;
    endfunction

    function automatic logic [N*XW-1:0] exp_x();
        logic [N*XW-1:0] v;
        for (int k = 0; k < N; k++) v[k*XW +: XW] = XW'(m_x[k]);
        return v;
    endfunction

    function automatic logic [N*YW-1:0] exp_y();
        logic [N*YW-1:0] v;
        for (int k = 0; k < N; k++) v[k*YW +: YW] = YW'(m_y[k]);
        return v;
    endfunction

    function automatic logic [SNAP_W-1:0] exp_snap();
        return {exp_active(), m_fired, &exp_active(), exp_x(), exp_y()};
    endfunction

    function automatic logic [SNAP_W-1:0] dut_snap();
        return {bus.o_active, bus.o_fired, bus.o_full, bus.o_bullet_x, bus.o_bullet_y};
    endfunction

    function automatic int live_count();
        int c = 0;
        for (int k = 0; k < N; k++) c += int'(m_active[k]);
        return c;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge and
    // return on the following falling edge so the outputs are stable.
    task automatic advance(input logic rst, input logic shoot,
                           input logic [N-1:0] hit, input logic [XW-1:0] sx);
        bit tick_now;
        bit do_spawn;
        int slot;
        i_reset      = rst;
        bus.i_shoot  = shoot;
        bus.i_hit    = hit;
        bus.i_ship_x = sx;
        @(posedge i_clk_25MHz);
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_active[k] = 1'b0;
                m_x[k]      = 0;
                m_y[k]      = (1 << YW) - 1;
            end
            m_cd    = 0;
            m_phase = 0;
            m_fired = 1'b0;
        end else begin
            tick_now = (m_phase == TICKS - 1);
            slot = -1;
            for (int k = 0; k < N; k++) if (!m_active[k] && slot < 0) slot = k;
            do_spawn = shoot && m_cd == 0 && slot >= 0;
            for (int k = 0; k < N; k++) begin
                if (m_active[k]) begin
                    if (hit[k] || (tick_now && m_y[k] == 0)) begin
                        m_active[k] = 1'b0;
                        m_x[k]      = 0;
                        m_y[k]      = (1 << YW) - 1;
                    end else if (tick_now) begin
                        m_y[k] = m_y[k] - 1;
                    end
                end
            end
            if (do_spawn) begin
                m_active[slot] = 1'b1;
                m_x[slot]      = int'(sx);
                m_y[slot]      = SPAWN_Y;
                m_cd           = CD;
            end else if (tick_now && m_cd > 0) begin
                m_cd = m_cd - 1;
            end
            m_fired = do_spawn;
            m_phase = (m_phase + 1) % TICKS;
        end
        @(negedge i_clk_25MHz);
    endtask

    task automatic test_reset();
        advance(1'b1, 1'b0, '0, '0);
        checks++;
        if (bus.o_active !== 4'b0000) $display("[TB] FAIL reset_active: got %b expected 0000", bus.o_active);
        else passes++;
        checks++;
        if (bus.o_bullet_x !== 20'h0) $display("[TB] FAIL reset_x: got %h expected 00000", bus.o_bullet_x);
        else passes++;
        checks++;
        if (bus.o_bullet_y !== 16'hFFFF) $display("[TB] FAIL reset_y: got %h expected ffff", bus.o_bullet_y);
        else passes++;
        checks++;
        if (bus.o_fired !== 1'b0 || bus.o_full !== 1'b0)
            $display("[TB] FAIL reset_flags: got fired=%b full=%b expected 0 0", bus.o_fired, bus.o_full);
        else passes++;
    endtask

    task automatic test_single_flight();
        bit saw_zero = 1'b0;
        advance(1'b0, 1'b1, '0, 5'd7);
        checks++;
        if (bus.o_active !== 4'b0001 || bus.o_bullet_x[4:0] !== 5'd7 ||
            bus.o_bullet_y[3:0] !== 4'd12 || bus.o_fired !== 1'b1)
            $display("[TB] FAIL flight_spawn: got act=%b x=%0d y=%0d fired=%b expected 0001 7 12 1",
                     bus.o_active, bus.o_bullet_x[4:0], bus.o_bullet_y[3:0], bus.o_fired);
        else passes++;
        for (int i = 0; i < 64; i++) begin
            advance(1'b0, 1'b0, '0, 5'd7);
            if (bus.o_active[0] === 1'b1 && bus.o_bullet_y[3:0] === 4'd0) saw_zero = 1'b1;
            checks++;
            if (dut_snap() !== exp_snap())
                $display("[TB] FAIL flight_cycle%0d: got %h expected %h", i, dut_snap(), exp_snap());
            else passes++;
        end
        checks++;
        if (saw_zero !== 1'b1) $display("[TB] FAIL flight_row0: got %b expected 1", saw_zero);
        else passes++;
        checks++;
        if (bus.o_active !== 4'b0000 || bus.o_bullet_y !== 16'hFFFF)
            $display("[TB] FAIL flight_retire: got act=%b y=%h expected 0000 ffff", bus.o_active, bus.o_bullet_y);
        else passes++;
    endtask

    task automatic test_cooldown_fill();
        int fired_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            advance(1'b0, 1'b1, '0, XW'($urandom_range(0, 31)));
            if (bus.o_fired === 1'b1) fired_cnt++;
            checks++;
            if (dut_snap() !== exp_snap())
                $display("[TB] FAIL fill_cycle%0d: got %h expected %h", i, dut_snap(), exp_snap());
            else passes++;
        end
        checks++;
        if (fired_cnt !== 4) $display("[TB] FAIL fill_count: got %0d expected 4", fired_cnt);
        else passes++;
        checks++;
        if (bus.o_full !== 1'b1) $display("[TB] FAIL fill_full: got %b expected 1", bus.o_full);
        else passes++;
    endtask

    task automatic test_hit();
        advance(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 40 && live_count() < 3; i++)
            advance(1'b0, 1'b1, '0, XW'($urandom_range(0, 31)));
        checks++;
        if (bus.o_active !== 4'b0111) $display("[TB] FAIL hit_setup: got %b expected 0111", bus.o_active);
        else passes++;
        advance(1'b0, 1'b0, 4'b0010, '0);
        checks++;
        if (bus.o_active !== 4'b0101 || bus.o_bullet_y[7:4] !== 4'hF)
            $display("[TB] FAIL hit_slot1: got act=%b y1=%h expected 0101 f", bus.o_active, bus.o_bullet_y[7:4]);
        else passes++;
        checks++;
        if (dut_snap() !== exp_snap())
            $display("[TB] FAIL hit_others: got %h expected %h", dut_snap(), exp_snap());
        else passes++;
    endtask

    task automatic test_hit_and_shoot();
        for (int i = 0; i < 40 && live_count() < N; i++)
            advance(1'b0, 1'b1, '0, XW'($urandom_range(0, 31)));
        for (int i = 0; i < 12 && m_cd != 0; i++)
            advance(1'b0, 1'b0, '0, '0);
        checks++;
        if (bus.o_full !== 1'b1) $display("[TB] FAIL hs_setup: got %b expected 1", bus.o_full);
        else passes++;
        advance(1'b0, 1'b1, 4'b0001, 5'd3);
        checks++;
        if (bus.o_active !== 4'b1110 || bus.o_fired !== 1'b0 || bus.o_bullet_y[3:0] !== 4'hF)
            $display("[TB] FAIL hs_retire: got act=%b fired=%b y0=%h expected 1110 0 f",
                     bus.o_active, bus.o_fired, bus.o_bullet_y[3:0]);
        else passes++;
        advance(1'b0, 1'b1, '0, 5'd21);
        checks++;
        if (bus.o_active !== 4'b1111 || bus.o_fired !== 1'b1 ||
            bus.o_bullet_x[4:0] !== 5'd21 || bus.o_bullet_y[3:0] !== 4'd12)
            $display("[TB] FAIL hs_respawn: got act=%b fired=%b x0=%0d y0=%0d expected 1111 1 21 12",
                     bus.o_active, bus.o_fired, bus.o_bullet_x[4:0], bus.o_bullet_y[3:0]);
        else passes++;
        checks++;
        if (dut_snap() !== exp_snap())
            $display("[TB] FAIL hs_model: got %h expected %h", dut_snap(), exp_snap());
        else passes++;
    endtask

    task automatic test_midflight_reset();
        advance(1'b0, 1'b0, 4'b1100, '0);
        for (int i = 0; i < 12 && m_cd != 0; i++)
            advance(1'b0, 1'b0, '0, '0);
        advance(1'b0, 1'b1, '0, 5'd17);
        checks++;
        if (bus.o_active !== 4'b0111 || m_cd == 0)
            $display("[TB] FAIL mr_setup: got act=%b cd=%0d expected 0111 nonzero", bus.o_active, m_cd);
        else passes++;
        advance(1'b1, 1'b1, 4'b0111, 5'd30);
        checks++;
        if (bus.o_active !== 4'b0000 || bus.o_bullet_y !== 16'hFFFF || bus.o_bullet_x !== 20'h0 ||
            bus.o_fired !== 1'b0 || bus.o_full !== 1'b0)
            $display("[TB] FAIL mr_clear: got %h expected %h", dut_snap(), exp_snap());
        else passes++;
        advance(1'b0, 1'b1, '0, 5'd9);
        checks++;
        if (bus.o_active !== 4'b0001 || bus.o_fired !== 1'b1 ||
            bus.o_bullet_x[4:0] !== 5'd9 || bus.o_bullet_y[3:0] !== 4'd12)
            $display("[TB] FAIL mr_first_shot: got act=%b fired=%b x0=%0d y0=%0d expected 0001 1 9 12",
                     bus.o_active, bus.o_fired, bus.o_bullet_x[4:0], bus.o_bullet_y[3:0]);
        else passes++;
    endtask

    task automatic test_random();
        logic [N-1:0] hit;
        advance(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) hit[k] = ($urandom_range(0, 9) == 0);
            advance(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1), hit,
                    XW'($urandom_range(0, 31)));
            checks++;
            if (dut_snap() !== exp_snap())
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, dut_snap(), exp_snap());
            else passes++;
        end
    endtask

    initial begin
        i_reset      = 1'b0;
        bus.i_shoot  = 1'b0;
        bus.i_hit    = '0;
        bus.i_ship_x = '0;
        test_reset();
        test_single_flight();
        test_cooldown_fill();
        test_hit();
        test_hit_and_shoot();
        test_midflight_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bullet_pool.md
# bullet_pool

Parametrised player-projectile manager for the Space Invaders playfield that replaces the single-bullet FSM. It holds up to N_BULLETS independent bullets, each spawned at the ship column and stepped upward on an internal move tick. It retires bullets on collision or on leaving the top row, and enforces a fire cooldown between shots. It sits between the input debouncer (i_shoot), the ship controller (i_ship_x) and the collision/render logic (per-slot hit in, per-slot position out).

## Interface
- N_BULLETS, 4, number of bullet slots (1..8)
- X_WIDTH, 5, column coordinate width
- Y_WIDTH, 4, row coordinate width
- SPAWN_Y, 12, row loaded on spawn (< 2^Y_WIDTH-1)
- TICK_CYCLES, 90000, clock cycles per move step (>= 2)
- COOLDOWN_TICKS, 2, move ticks after a spawn during which i_shoot is ignored (0 = no cooldown)

Ports:
- i_clk_25MHz  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_shoot  in  1  fire request, level-sampled every cycle
- i_hit  in  N_BULLETS  per-slot collision flag from collision logic
- i_ship_x  in  X_WIDTH  current ship column
- o_bullet_x  out  N_BULLETS*X_WIDTH  slot k at bits [k*X_WIDTH +: X_WIDTH]
- o_bullet_y  out  N_BULLETS*Y_WIDTH  slot k at bits [k*Y_WIDTH +: Y_WIDTH]
- o_active  out  N_BULLETS  slot k holds a live bullet
- o_fired  out  1  one-cycle pulse when a spawn occurs
- o_full  out  1  all slots active (combinational from o_active)

## Operation
- Tick generator: counter 0..TICK_CYCLES-1. Internal tick is high for the one cycle when the counter equals TICK_CYCLES-1, then the counter wraps to 0.
- Each slot has two states, IDLE and MOVING (o_active = MOVING).
- IDLE slot outputs: x = 0, y = all ones (off-screen marker).
- Spawn conditions, all evaluated on pre-edge state: i_shoot=1, cooldown counter = 0, at least one IDLE slot.
- On spawn, the lowest-index IDLE slot becomes MOVING with x = i_ship_x and y = SPAWN_Y. o_fired=1 for one cycle, and the cooldown loads COOLDOWN_TICKS.
- Only one spawn occurs per cycle. A held i_shoot re-fires once the cooldown expires, and again only if a slot is free.
- i_shoot when no slot is free, or while cooldown is nonzero, is dropped. Nothing is queued.
- MOVING slot, per-cycle priority:
  1. i_hit[k]=1: go to IDLE.
  2. tick with y = 0: go to IDLE (bullet leaves the top; never wraps to all-ones).
  3. tick: y <= y-1.
  4. Otherwise hold.
- i_hit[k] on an IDLE slot is ignored.
- Cooldown decrements by 1 on each tick while nonzero, saturating at 0.
- Slots are fully independent. Any number may retire in the same cycle.

## Timing
- Reset (one cycle of i_reset=1) gives:
  - all slots IDLE
  - o_bullet_x = 0, o_bullet_y = all ones
  - o_active = 0, o_fired = 0, o_full = 0
  - tick counter = 0, cooldown = 0
- Reset mid-flight overrides all other inputs in that cycle.
- All outputs except o_full are registered.
- Spawn latency: i_shoot sampled at edge n; the slot's position, o_active and o_fired are visible after edge n. o_fired drops after edge n+1.
- Hit/retire latency: one edge. A slot retired at edge n is not eligible for allocation until edge n+1, because allocation uses pre-edge state.
- A slot spawned at edge n does not move at edge n even if tick is high that cycle. Its first decrement is at the next tick.
- First tick after reset occurs in cycle TICK_CYCLES-1, so the first step is at edge TICK_CYCLES.
- Simultaneous hit on slot j and spawn: both happen. The spawn takes the lowest IDLE slot other than j.
- Y arithmetic is unsigned Y_WIDTH and never underflows, because y = 0 with tick retires the slot.

## Test plan
Bench uses TICK_CYCLES=4, COOLDOWN_TICKS=1, N_BULLETS=4, SPAWN_Y=12.

- **Reset:** assert i_reset 1 cycle -> o_active=0000; every slot x=0, y=15; o_fired=0.
- **Single flight:** i_ship_x=7, pulse i_shoot -> slot0 x=7, y=12 next cycle with one o_fired pulse. y then steps 11, 10, ... 0, one step every 4 cycles. At the tick after y=0 the slot returns to IDLE with y=15, never 15-after-wrap.
- **Cooldown and fill:** hold i_shoot with x varying -> spawns spaced by the cooldown tick into slots 0, 1, 2, 3 in order. o_full=1 after the fourth. Further i_shoot produces no o_fired.
- **Hit:** with slots 0-2 live, i_hit=0010 -> slot1 IDLE (y=15) after one edge; slots 0 and 2 unaffected.
- **Simultaneous hit and shoot:** pool full, i_hit=0001 together with i_shoot (cooldown 0) -> slot0 retires, no spawn that cycle. A shoot on the next cycle spawns into slot0.
- **Mid-flight reset:** reset with 3 live bullets and cooldown nonzero -> all IDLE. The first shoot after reset spawns immediately into slot0.
